// File: rtl/deadlock_kernel_block_detector_if.sv
// Signal bundle between the kernel monitor top and the block detector.
// The master drives the monitor vectors and clear; the slave returns the block status.
interface deadlock_kernel_block_detector_if #(
    parameter int unsigned N_AXIS = 2,
    parameter int unsigned N_INST = 5,
    parameter int unsigned N_IDLE = 9,
    parameter int unsigned CNT_W  = 16
);
    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_IDLE-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              clear;
    logic              block;
    logic              block_pulse;
    logic              ever_blocked;
    logic [N_INST-1:0] blocked_inst_mask;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_pulse, ever_blocked, blocked_inst_mask, stall_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_pulse, ever_blocked, blocked_inst_mask, stall_count
    );
endinterface

// File: rtl/deadlock_kernel_block_detector.sv
// Debounces the combinational kernel-stuck condition into a registered block indication,
// capturing the blocked instances on entry and counting consecutive stuck cycles.
module deadlock_kernel_block_detector #(
    parameter int unsigned N_AXIS         = 2,
    parameter int unsigned N_INST         = 5,
    parameter int unsigned N_IDLE         = 9,
    parameter int unsigned PERSIST_CYCLES = 16,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clock,
    input  logic reset,
    deadlock_kernel_block_detector_if.slave mon
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] PERSIST = CNT_W'(PERSIST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              block_q, block_d;
    logic              pulse_q, pulse_d;
    logic              ever_q, ever_d;
    logic [N_INST-1:0] mask_q, mask_d;

    logic all_parked_c, any_blk_c, active_c, stuck_c;

    // Every instance is either idle or blocked, and at least one is blocked.
    assign all_parked_c = &(mon.inst_idle_sigs[N_INST-1:0] | mon.inst_block_sigs);
    assign any_blk_c    = |mon.inst_block_sigs;

    generate
        if (N_IDLE > N_INST) begin : g_qual
            assign active_c = ~&mon.inst_idle_sigs[N_IDLE-1:N_INST];
        end else begin : g_noqual
            assign active_c = 1'b1;
        end
    endgenerate

    // A waiting AXIS port means the stall belongs to the testbench, not the kernel.
    assign stuck_c = all_parked_c & any_blk_c & ~|mon.axis_block_sigs & active_c;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            stall_q <= '0;
            block_q <= 1'b0;
            pulse_q <= 1'b0;
            ever_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            block_q <= block_d;
            pulse_q <= pulse_d;
            ever_q  <= ever_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        ever_d  = ever_q;
        mask_d  = mask_q;
        pulse_d = 1'b0;

        if (mon.clear) begin
            state_d = RUN;
            stall_d = '0;
            ever_d  = 1'b0;
            mask_d  = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (stuck_c) begin
                        stall_d = CNT_ONE;
                        state_d = (PERSIST == CNT_ONE) ? BLOCKED : SUSPECT;
                    end else begin
                        stall_d = '0;
                    end
                end
                SUSPECT: begin
                    if (stuck_c) begin
                        stall_d = stall_q + CNT_ONE;
                        if (stall_d == PERSIST) begin
                            state_d = BLOCKED;
                        end
                    end else begin
                        state_d = RUN;
                        stall_d = '0;
                    end
                end
                BLOCKED: begin
                    if (stuck_c) begin
                        stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_ONE;
                    end else begin
                        state_d = RUN;
                        stall_d = '0;
                    end
                end
                default: begin
                    state_d = RUN;
                    stall_d = '0;
                end
            endcase

            // Fresh entry into BLOCKED strobes and snapshots the culprits.
            if (state_d == BLOCKED && state_q != BLOCKED) begin
                pulse_d = 1'b1;
                ever_d  = 1'b1;
                mask_d  = mon.inst_block_sigs;
            end
        end

        block_d = (state_d == BLOCKED);
    end

    assign mon.block             = block_q;
    assign mon.block_pulse       = pulse_q;
    assign mon.ever_blocked      = ever_q;
    assign mon.blocked_inst_mask = mask_q;
    assign mon.stall_count       = stall_q;

endmodule

// File: doc/deadlock_kernel_block_detector.md
Name: deadlock_kernel_block_detector

Overview:
Evaluation stage for the per-kernel deadlock monitor. Consumes the AXIS-block, instance-idle and instance-block vectors assembled by the kernel monitor top and produces a debounced kernel-block indication. It captures which instances were blocked when the indication fired and keeps a stall-duration counter. It sits between the signal-gathering top and the simulation reporting logic, which prints on the rising edge of `block`.

Parameters:
N_AXIS, 2, width of axis_block_sigs
N_INST, 5, number of monitored dataflow instances (width of inst_block_sigs)
N_IDLE, 9, width of inst_idle_sigs; bits [N_INST-1:0] pair with inst_block_sigs, bits [N_IDLE-1:N_INST] are activity qualifiers
PERSIST_CYCLES, 16, consecutive stuck cycles required before block asserts; legal range 1..2^CNT_W-1
CNT_W, 16, width of stall_count

Ports:
clock  in  1  monitor clock, rising edge
reset  in  1  asynchronous, active-low reset
axis_block_sigs  in  N_AXIS  1 = top-level AXIS port waiting on the testbench
inst_idle_sigs  in  N_IDLE  per-instance ap_idle and qualifier idles
inst_block_sigs  in  N_INST  1 = instance stalled on FIFO or handshake
clear  in  1  synchronous clear of state, counters and captures
block  out  1  debounced kernel deadlock indication
block_pulse  out  1  one-cycle strobe on the cycle block rises
ever_blocked  out  1  sticky; set with block, cleared only by reset or clear
blocked_inst_mask  out  N_INST  inst_block_sigs captured when block rises
stall_count  out  CNT_W  consecutive stuck cycles, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=RUN; block, block_pulse, ever_blocked = 0; blocked_inst_mask = 0; stall_count = 0.
- The stuck condition is combinational from the inputs. stuck = all_parked & any_blk & ~|axis_block_sigs & active, where:
  - all_parked = AND over i<N_INST of (inst_idle_sigs[i] | inst_block_sigs[i])
  - any_blk = |inst_block_sigs
  - active = ~&inst_idle_sigs[N_IDLE-1:N_INST]; if N_IDLE==N_INST, active=1
- Any blocked AXIS port vetoes stuck, because that stall is the testbench's responsibility.
- All outputs are registered. The inputs are not registered.
- FSM states: RUN, SUSPECT, BLOCKED.
  - RUN:
    - stuck & PERSIST_CYCLES==1 -> BLOCKED, stall_count=1.
    - stuck otherwise -> SUSPECT, stall_count=1.
    - ~stuck -> stay, stall_count=0.
  - SUSPECT:
    - ~stuck -> RUN, stall_count=0.
    - stuck -> stall_count+1. If the new value == PERSIST_CYCLES -> BLOCKED.
  - BLOCKED:
    - stuck -> stay, stall_count+1 saturating at 2^CNT_W-1.
    - ~stuck -> RUN, stall_count=0, block deasserts on that edge.
- Entry into BLOCKED, on the same edge:
  - block=1
  - block_pulse=1 for exactly one cycle
  - ever_blocked=1
  - blocked_inst_mask <= current inst_block_sigs
- Latency: if stuck holds at P consecutive rising edges, block is 1 after the P-th edge. A single non-stuck edge restarts the count.
- Re-entry: after leaving BLOCKED, a fresh entry re-captures blocked_inst_mask and re-pulses block_pulse.
- clear=1 at an edge:
  - state=RUN; stall_count, block, block_pulse, ever_blocked, blocked_inst_mask = 0.
  - clear wins over a simultaneous stuck. Counting resumes at the first edge with clear=0.
- Reset asserted mid-SUSPECT or mid-BLOCKED drops all outputs immediately (asynchronous). Reset release is applied synchronously to the next edge.
- X on inputs while reset=0 must not corrupt state. The bench drives known values.

Test Plan:
- Reset with all inputs 0 -> all outputs 0. Idle all 1, block all 0 for 100 cycles (qualifier bit 5 = 0) -> block stays 0, stall_count 0.
- Instance 2 blocked, other instances idle, axis 0, qualifier idle bit5=0, PERSIST_CYCLES=16:
  - block=1 after the 16th edge
  - block_pulse high for one cycle only
  - blocked_inst_mask=5'b00100, ever_blocked=1
- Same stuck pattern, then stuck drops at edge 10 and resumes -> block stays 0 until 16 further consecutive stuck edges; stall_count returns to 0 at edge 10.
- Stuck pattern with axis_block_sigs=2'b01 -> block never asserts. Deassert axis -> block after 16 edges.
- In BLOCKED, stuck drops -> block=0 next edge, ever_blocked stays 1, mask retained. Then clear=1 concurrent with stuck -> all outputs 0, state RUN.
- PERSIST_CYCLES=1: block after the 1st stuck edge. CNT_W=4 held stuck 40 cycles -> stall_count saturates at 15. Async reset mid-BLOCKED -> outputs 0 without a clock edge.
